uart_rx_fifo_top: RTL and testbench
===================================

Name: uart_rx_fifo_top

Overview:
- Serial receiver for the RX pin: 8N1 UART, mid-bit 3-sample majority vote, false-start rejection, framing and overrun detection.
- Received bytes go into a small first-word-fall-through FIFO with a valid/ready interface.
- Sits between the board RX pad and any byte consumer in the 12 MHz clk domain, e.g. a serial loader or debug monitor.
- It is the receive-side counterpart of the existing TX path.

Parameters:
- CLK_HZ, 12000000, clk frequency in Hz.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, (CLK_HZ+BAUD/2)/BAUD (=104), clocks per bit period; must be >= 8.
- FIFO_DEPTH, 4, byte entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  asynchronous, active-high reset.
- RX  in  1  asynchronous serial input, idle high.
- rx_data  out  8  head-of-FIFO byte; 8'h00 when rx_valid=0.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts; a pop occurs when rx_valid && rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- rx_busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE, synchronizer flops to 1, counters and pointers 0, FIFO contents 0.
  - Outputs: rx_valid=0, rx_data=0, frame_err=0, overrun=0, rx_busy=0.
  - Reset asserted mid-frame aborts the frame; nothing is pushed.
- Input synchronizer: 2-flop, reset to 1. All decisions use the synchronized signal rxs.
- Bit timing: counter bit_cnt runs 0..CLKS_PER_BIT-1. mid = CLKS_PER_BIT/2 (=52).
- Sampling: samples taken at bit_cnt = mid-1, mid, mid+1; bit value = majority of the three. The decision is made at mid+1.
- IDLE: on rxs=0, go to START with bit_cnt=0.
- START: at the decision point:
  - majority 0 → continue to end of bit, then DATA.
  - majority 1 → false start; return to IDLE at once; no flags.
- DATA: 8 bits, LSB first, shifted into the shift register at each decision. After bit 7 ends, go to STOP.
- STOP: at the decision point:
  - majority 1 → push request this edge, then IDLE (the second half of the stop bit is not waited on, so back-to-back frames are tolerated).
  - majority 0 → frame_err pulse, byte discarded, go to BREAK.
- BREAK: wait for rxs=1, then IDLE. A line held low does not generate repeated frame errors.
- rx_busy = (state != IDLE).
- FIFO, first-word-fall-through:
  - A push edge writes mem[wr_ptr]; rx_valid is high from the next cycle.
  - Latency from the stop-bit decision edge to rx_valid=1 is 1 cycle when empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full when the MSBs differ and the rest match; empty when equal.
  - Push while full, with no pop the same edge → byte dropped, overrun pulse.
  - Push and pop on the same edge when full → both succeed, no overrun.
  - Push and pop on the same edge when count=1 → count stays 1, rx_valid stays 1, rx_data shows the new byte next cycle.
  - Pop when empty → no effect.
- frame_err and overrun are registered, high exactly one cycle, and never asserted together for the same frame.

Decomposition:
- Shared include uart_defs.vh:
  - FSM state encodings: IDLE, START, DATA, STOP, BREAK (3 bits).
  - Helper macro for CLKS_PER_BIT rounding.
- One sub-module, uart_sync_fifo: parameters WIDTH and DEPTH; ports push, din, pop, dout, valid, full, with the same async reset. The top keeps the synchronizer, FSM, sampling and flags.

Test Plan:
- Send 8'hA5 at 104 clk/bit, rx_ready=1 → rx_valid for 1 cycle with rx_data=8'hA5, 1 cycle after the stop decision; frame_err=0, overrun=0.
- 20-cycle low glitch on RX → FSM returns to IDLE, rx_busy drops, no push, no flags.
- Frame 8'h3C with stop bit 0, then RX low for 2000 cycles, then high; then send 8'h11 → exactly one frame_err pulse, 8'h3C not delivered, 8'h11 received correctly.
- rx_ready=0; send 8'h01..8'h05 back-to-back → first four held in order, overrun pulses once on the fifth. Then rx_ready=1 → pops yield 01, 02, 03, 04, then rx_valid=0 and rx_data=8'h00.
- FIFO full; pulse rx_ready on the exact edge a sixth byte 8'h66 is pushed → no overrun; 8'h66 is last in the pop order.
- Assert reset for 3 cycles at DATA bit 4 of a frame, release → outputs all 0; the partial frame is never delivered; the next frame 8'h5A is received correctly; baud tolerance passes at ±3% bit-period skew.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM states and small helpers.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Rounded clocks-per-bit so the bit period error stays under half a clock.
  function automatic int clksPerBit(input int clkHz, input int baud);
    return (clkHz + baud / 2) / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small first-word-fall-through FIFO; head word is visible whenever valid is high.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush, doPop;

  // One extra pointer bit tells full from empty when the indices match.
  assign valid   = (wrPtr_q != rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop   = pop && valid;
  assign doPush  = push && (!full || doPop);
  assign wrPtr_d = wrPtr_q + (AW+1)'(1);
  assign rdPtr_d = rdPtr_q + (AW+1)'(1);
  assign dout    = valid ? mem_q[rdPtr_q[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= din;
        wrPtr_q                <= wrPtr_d;
      end
      if (doPop) rdPtr_q <= rdPtr_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_top.sv
// 8N1 UART receiver with mid-bit majority sampling, false-start rejection,
// framing/overrun pulses and a FWFT byte FIFO towards the consumer.
module uart_rx_fifo_top
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clksPerBit(CLK_HZ, BAUD),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_LO = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] MID_HI = CW'(CLKS_PER_BIT / 2 + 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic          samp0_q, samp1_q;
  logic          frameErr_q, overrun_q;
  logic          rxs, decide, bitEnd, bitVal, push, popOk, fifoFull;

  assign rxs      = sync_q[1];
  assign decide   = (bitCnt_q == MID_HI);
  assign bitEnd   = (bitCnt_q == LAST);
  assign bitCnt_d = bitEnd ? '0 : bitCnt_q + CW'(1);
  assign bitVal   = majority3(samp0_q, samp1_q, rxs);
  // Push lands on the stop-bit decision edge itself, giving one cycle to rx_valid.
  assign push     = (state_q == STOP) && decide && bitVal;
  assign popOk    = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RX};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      overrun_q  <= push && fifoFull && !popOk;
      if (bitCnt_q == MID_LO) samp0_q <= rxs;
      if (bitCnt_q == MID)    samp1_q <= rxs;
      unique case (state_q)
        IDLE: begin
          bitCnt_q <= '0;
          if (!rxs) state_q <= START;
        end
        START: begin
          bitCnt_q <= bitCnt_d;
          if (decide && bitVal) begin
            state_q <= IDLE;
          end else if (bitEnd) begin
            state_q  <= DATA;
            bitIdx_q <= '0;
          end
        end
        DATA: begin
          bitCnt_q <= bitCnt_d;
          if (decide) shift_q <= {bitVal, shift_q[7:1]};
          if (bitEnd) begin
            if (bitIdx_q == 3'd7) state_q <= STOP;
            bitIdx_q <= bitIdx_q + 3'd1;
          end
        end
        STOP: begin
          bitCnt_q <= bitCnt_d;
          if (decide) begin
            if (bitVal) begin
              state_q <= IDLE;
            end else begin
              state_q    <= BREAK;
              frameErr_q <= 1'b1;
            end
          end
        end
        // A held-low line stays here so it reports a single framing error.
        BREAK: begin
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (shift_q),
    .pop  (rx_ready),
    .dout (rx_data),
    .valid(rx_valid),
    .full (fifoFull)
  );

  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Self-checking bench for uart_rx_fifo_top: vector table, corner sequences and
// randomized frames compared against a queue-based model of the receiver.
module tb_uart_rx_fifo_top;

  localparam int CPB        = 104;
  localparam int DEPTH      = 4;
  localparam int DECIDE_LAT = 9 * CPB + CPB / 2 + 4;

  typedef struct {
    logic [7:0] data;
    bit         stopOk;
    int         bitClks;
    int         extraLow;
    int         expPops;
    logic [7:0] expData;
    int         expFerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int startCycle = 0;

  logic [7:0] popQ[$];
  int         ferrCnt = 0;
  int         ovrCnt = 0;
  int         validHi = 0;
  int         busyCycles = 0;
  int         riseCycle = 0;
  int         invErrors = 0;
  logic       prevValid = 1'b0;

  logic [7:0] modelQ[$];
  logic [7:0] expQ[$];
  vec_t       vecs[7];

  uart_rx_fifo_top dut (
    .clk      (clk),
    .reset    (reset),
    .RX       (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Observes the consumer side on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) popQ.push_back(rx_data);
    if (frame_err === 1'b1) ferrCnt++;
    if (overrun === 1'b1) ovrCnt++;
    if (rx_valid === 1'b1) validHi++;
    if (rx_busy === 1'b1) busyCycles++;
    if (rx_valid === 1'b1 && prevValid !== 1'b1) riseCycle = cycleNo;
    prevValid = rx_valid;
    if ((rx_valid === 1'b0 && rx_data !== 8'h00) || (frame_err === 1'b1 && overrun === 1'b1)) begin
      invErrors++;
      if (invErrors <= 5)
        $display("[TB] FAIL invariant at cycle %0d: valid=%b data=%h ferr=%b ovr=%b, required data=00 when idle and no joint flags",
                 cycleNo, rx_valid, rx_data, frame_err, overrun);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; bits change just after a rising edge.
  task automatic applyStimulus(input logic [7:0] data, input bit stopOk, input int bitClks, input int extraLow);
    logic [9:0] frame;
    frame = {stopOk, data, 1'b0};
    @(posedge clk);
    #1;
    startCycle = cycleNo + 1;
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (bitClks) @(posedge clk);
      #1;
    end
    if (extraLow > 0) begin
      RX = 1'b0;
      repeat (extraLow) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rx_valid"}, int'(rx_valid), 0);
    checkOutput({tag, " rx_data"}, int'(rx_data), 0);
    checkOutput({tag, " frame_err"}, int'(frame_err), 0);
    checkOutput({tag, " overrun"}, int'(overrun), 0);
    checkOutput({tag, " rx_busy"}, int'(rx_busy), 0);
  endtask

  initial begin
    int p0, f0, o0, h0, b0, expFerr, expOvr, n;
    logic [7:0] d;
    bit ok;
    int clks;

    reset = 1'b1;
    RX = 1'b1;
    rx_ready = 1'b1;

    vecs[0] = '{8'hA5, 1'b1, 104,    0, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 104, 2000, 0, 8'h00, 1};
    vecs[2] = '{8'h11, 1'b1, 104,    0, 1, 8'h11, 0};
    vecs[3] = '{8'h00, 1'b1, 104,    0, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 104,    0, 1, 8'hFF, 0};
    vecs[5] = '{8'h5A, 1'b1, 101,    0, 1, 8'h5A, 0};
    vecs[6] = '{8'hC3, 1'b1, 107,    0, 1, 8'hC3, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    for (int v = 0; v < 7; v++) begin
      p0 = popQ.size(); f0 = ferrCnt; o0 = ovrCnt; h0 = validHi;
      applyStimulus(vecs[v].data, vecs[v].stopOk, vecs[v].bitClks, vecs[v].extraLow);
      idleCycles(60);
      checkOutput($sformatf("vec%0d pops", v), popQ.size() - p0, vecs[v].expPops);
      if (vecs[v].expPops == 1 && popQ.size() > p0) begin
        checkOutput($sformatf("vec%0d data", v), int'(popQ[p0]), int'(vecs[v].expData));
        checkOutput($sformatf("vec%0d latency", v), riseCycle - startCycle, DECIDE_LAT);
        checkOutput($sformatf("vec%0d valid width", v), validHi - h0, 1);
      end
      checkOutput($sformatf("vec%0d frame_err pulses", v), ferrCnt - f0, vecs[v].expFerr);
      checkOutput($sformatf("vec%0d overrun pulses", v), ovrCnt - o0, 0);
      checkOutput($sformatf("vec%0d rx_busy", v), int'(rx_busy), 0);
    end

    // Short low glitch must be rejected as a false start.
    p0 = popQ.size(); f0 = ferrCnt; o0 = ovrCnt; b0 = busyCycles;
    @(posedge clk);
    #1 RX = 1'b0;
    repeat (20) @(posedge clk);
    #1 RX = 1'b1;
    idleCycles(100);
    checkOutput("glitch busy seen", int'(busyCycles > b0), 1);
    checkOutput("glitch rx_busy", int'(rx_busy), 0);
    checkOutput("glitch pops", popQ.size() - p0, 0);
    checkOutput("glitch frame_err", ferrCnt - f0, 0);
    checkOutput("glitch overrun", ovrCnt - o0, 0);

    // Five back-to-back bytes into a stalled consumer.
    rx_ready = 1'b0;
    modelQ.delete();
    expOvr = 0;
    p0 = popQ.size(); o0 = ovrCnt;
    for (int b = 1; b <= 5; b++) begin
      applyStimulus(8'(b), 1'b1, CPB, 0);
      if (modelQ.size() < DEPTH) modelQ.push_back(8'(b));
      else expOvr++;
    end
    idleCycles(20);
    checkOutput("stall valid held", int'(rx_valid), 1);
    checkOutput("stall overrun pulses", ovrCnt - o0, expOvr);
    rx_ready = 1'b1;
    idleCycles(10);
    checkOutput("stall pops", popQ.size() - p0, modelQ.size());
    n = popQ.size() - p0;
    if (n > modelQ.size()) n = modelQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("stall pop %0d", i), int'(popQ[p0 + i]), int'(modelQ[i]));
    @(negedge clk);
    checkOutput("drained rx_valid", int'(rx_valid), 0);
    checkOutput("drained rx_data", int'(rx_data), 0);

    // Full FIFO with a pop on the very edge the sixth byte is pushed.
    #1 rx_ready = 1'b0;
    modelQ.delete();
    p0 = popQ.size(); o0 = ovrCnt;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(8'h61 + 8'(b), 1'b1, CPB, 0);
      modelQ.push_back(8'h61 + 8'(b));
    end
    fork
      applyStimulus(8'h66, 1'b1, CPB, 0);
      begin
        @(negedge RX);
        repeat (DECIDE_LAT) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    expQ.delete();
    expQ.push_back(modelQ.pop_front());
    modelQ.push_back(8'h66);
    while (modelQ.size() > 0) expQ.push_back(modelQ.pop_front());
    idleCycles(20);
    checkOutput("full+pop overrun", ovrCnt - o0, 0);
    rx_ready = 1'b1;
    idleCycles(10);
    checkOutput("full+pop pops", popQ.size() - p0, expQ.size());
    n = popQ.size() - p0;
    if (n > expQ.size()) n = expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("full+pop order %0d", i), int'(popQ[p0 + i]), int'(expQ[i]));

    // Reset in the middle of data bit 4; the tail of the frame stays high.
    p0 = popQ.size();
    fork
      applyStimulus(8'hF5, 1'b1, CPB, 0);
      begin
        @(negedge RX);
        repeat (572) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkAllZero("midframe reset");
      end
    join
    idleCycles(100);
    checkOutput("midframe reset pops", popQ.size() - p0, 0);
    p0 = popQ.size();
    applyStimulus(8'h5A, 1'b1, CPB, 0);
    idleCycles(20);
    checkOutput("post-reset pops", popQ.size() - p0, 1);
    if (popQ.size() > p0) checkOutput("post-reset data", int'(popQ[p0]), 'h5A);

    // Random frames with skew and occasional bad stop bits, consumer always ready.
    expQ.delete();
    expFerr = 0;
    p0 = popQ.size(); f0 = ferrCnt; o0 = ovrCnt;
    for (int r = 0; r < 20; r++) begin
      d = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      clks = $urandom_range(101, 107);
      applyStimulus(d, ok, clks, 0);
      if (ok) expQ.push_back(d);
      else expFerr++;
      idleCycles($urandom_range(5, 40));
    end
    idleCycles(50);
    checkOutput("random pops", popQ.size() - p0, expQ.size());
    checkOutput("random frame_err", ferrCnt - f0, expFerr);
    checkOutput("random overrun", ovrCnt - o0, 0);
    n = popQ.size() - p0;
    if (n > expQ.size()) n = expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("random byte %0d", i), int'(popQ[p0 + i]), int'(expQ[i]));

    checkOutput("invariant violations", invErrors, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
